// File: rtl/svpwm_carrier_compare.sv
// SVPWM carrier/compare stage: min-max zero-sequence injection, threshold
// conversion, up/down triangular carrier, valley-synchronous shadow load and
// per-phase complementary gate generation with programmable dead time.
module svpwm_carrier_compare #(
  parameter int CNT_W = 12,
  parameter int DEAD  = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enb,
  input  logic signed [15:0]      va,
  input  logic signed [15:0]      vb,
  input  logic signed [15:0]      vc,
  input  logic signed [15:0]      vmin,
  input  logic signed [15:0]      vmax,
  output logic                    pwm_ah,
  output logic                    pwm_al,
  output logic                    pwm_bh,
  output logic                    pwm_bl,
  output logic                    pwm_ch,
  output logic                    pwm_cl,
  output logic                    carrier_sync,
  output logic [CNT_W-1:0]        carrier
);

  localparam int               DC_W   = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
  localparam logic [CNT_W-1:0] CMAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HALF   = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DC_W-1:0]  DEAD_V = DC_W'(DEAD);
  localparam logic [DC_W-1:0]  DC_ONE = DC_W'(1);

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  logic signed [15:0] v_in     [3];
  logic signed [16:0] vsum;
  logic signed [16:0] off;
  logic signed [17:0] diff     [3];
  logic        [15:0] biased   [3];

  logic signed [15:0] mod_q    [3];
  logic signed [15:0] mod_d    [3];
  logic [CNT_W-1:0]   thr_q    [3];
  logic [CNT_W-1:0]   thr_d    [3];
  logic [CNT_W-1:0]   shadow_q [3];
  logic [CNT_W-1:0]   shadow_d [3];

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dir_e               dir_q, dir_d;
  logic               sync_q, sync_d;

  logic [2:0]         raw;
  logic [2:0]         s_q, s_d;
  logic [2:0]         h_q, h_d;
  logic [2:0]         l_q, l_d;
  logic [DC_W-1:0]    dc_q     [3];
  logic [DC_W-1:0]    dc_d     [3];

  // Injection and threshold pipeline: remove the min-max midpoint, saturate, then bias to unsigned and keep the top CNT_W bits.
  always_comb begin
    v_in[0] = va;
    v_in[1] = vb;
    v_in[2] = vc;
    vsum    = {vmin[15], vmin} + {vmax[15], vmax};
    off     = vsum >>> 1;
    for (int k = 0; k < 3; k++) begin
      diff[k]   = {{2{v_in[k][15]}}, v_in[k]} - {off[16], off};
      biased[k] = {~mod_q[k][15], mod_q[k][14:0]};
      mod_d[k]  = mod_q[k];
      thr_d[k]  = thr_q[k];
      if (enb) begin
        if (diff[k] > 18'sd32767) begin
          mod_d[k] = 16'sh7fff;
        end else if (diff[k] < -18'sd32768) begin
          mod_d[k] = 16'sh8000;
        end else begin
          mod_d[k] = diff[k][15:0];
        end
        thr_d[k] = biased[k][15 -: CNT_W];
      end
    end
  end

  // Triangular carrier plus valley-synchronous shadow load; the sync pulse is registered alongside the load.
  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    sync_d = 1'b0;
    for (int k = 0; k < 3; k++) begin
      shadow_d[k] = shadow_q[k];
    end
    if (enb) begin
      if (dir_q == DIR_UP) begin
        if (cnt_q == CMAX) begin
          cnt_d = CMAX - ONE;
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d = ONE;
          dir_d = DIR_UP;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      if (cnt_q == '0) begin
        sync_d = 1'b1;
        for (int k = 0; k < 3; k++) begin
          shadow_d[k] = thr_q[k];
        end
      end
    end
  end

  // Compare and dead time: gates follow the stored state only once it has been stable for DEAD edges, so the gap is exactly DEAD cycles.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      raw[k]  = (shadow_q[k] > cnt_q);
      s_d[k]  = s_q[k];
      dc_d[k] = dc_q[k];
      h_d[k]  = h_q[k];
      l_d[k]  = l_q[k];
      if (enb) begin
        if (DEAD == 0) begin
          s_d[k] = raw[k];
          h_d[k] = raw[k];
          l_d[k] = ~raw[k];
        end else if (raw[k] != s_q[k]) begin
          s_d[k]  = raw[k];
          dc_d[k] = DEAD_V;
          h_d[k]  = 1'b0;
          l_d[k]  = 1'b0;
        end else if (dc_q[k] != '0) begin
          dc_d[k] = dc_q[k] - DC_ONE;
          if (dc_q[k] == DC_ONE) begin
            h_d[k] = s_q[k];
            l_d[k] = ~s_q[k];
          end else begin
            h_d[k] = 1'b0;
            l_d[k] = 1'b0;
          end
        end else begin
          h_d[k] = s_q[k];
          l_d[k] = ~s_q[k];
        end
      end
    end
  end

  // State registers; the stored state resets to 1 because the reset shadow (half scale) exceeds cnt=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      sync_q <= 1'b0;
      s_q    <= 3'b111;
      h_q    <= 3'b000;
      l_q    <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        mod_q[k]    <= '0;
        thr_q[k]    <= HALF;
        shadow_q[k] <= HALF;
        dc_q[k]     <= DEAD_V;
      end
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      sync_q <= sync_d;
      s_q    <= s_d;
      h_q    <= h_d;
      l_q    <= l_d;
      for (int k = 0; k < 3; k++) begin
        mod_q[k]    <= mod_d[k];
        thr_q[k]    <= thr_d[k];
        shadow_q[k] <= shadow_d[k];
        dc_q[k]     <= dc_d[k];
      end
    end
  end

  assign pwm_ah       = h_q[0];
  assign pwm_al       = l_q[0];
  assign pwm_bh       = h_q[1];
  assign pwm_bl       = l_q[1];
  assign pwm_ch       = h_q[2];
  assign pwm_cl       = l_q[2];
  assign carrier_sync = sync_q;
  assign carrier      = cnt_q;

endmodule
